// File: rtl/rect_linear_grad_pkg.sv
// rtl/rect_linear_grad_pkg.sv - shared widths, depths and FIFO state type for the ReLU backward stage
package rect_linear_grad_pkg;

  // Network data width; values are signed two's complement.
  localparam int NN_WIDTH    = 16;
  localparam int NN_BITWIDTH = NN_WIDTH - 1;

  // Default depth of the ReLU mask FIFO.
  localparam int RELU_MASK_DEPTH = 64;

  // Occupancy classes of the mask FIFO, derived from its count.
  typedef enum logic [1:0] {
    FIFO_EMPTY   = 2'd0,
    FIFO_PARTIAL = 2'd1,
    FIFO_FULL    = 2'd2
  } fifo_state_e;

endpackage

// File: rtl/rect_linear_grad_mask_fifo.sv
// rtl/rect_linear_grad_mask_fifo.sv - 1-bit wide mask FIFO, reusable by other backprop stages
module rect_linear_grad_mask_fifo
  import rect_linear_grad_pkg::*;
#(
  parameter int DEPTH = RELU_MASK_DEPTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic          din,
  output logic          dout,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [DEPTH-1:0] mem;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  fifo_state_e      state;
  logic             do_push;
  logic             do_pop;

  // Classify occupancy; full/empty are read straight off the class.
  always_comb begin
    state = FIFO_PARTIAL;
    if (cnt == '0) begin
      state = FIFO_EMPTY;
    end else if (cnt == FULL_COUNT) begin
      state = FIFO_FULL;
    end
  end

  assign full  = (state == FIFO_FULL);
  assign empty = (state == FIFO_EMPTY);

  // A flush cycle discards any push or pop presented with it.
  assign do_push = push && !full  && !flush;
  assign do_pop  = pop  && !empty && !flush;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW + 1)'(1);
        2'b01:   cnt <= cnt - (AW + 1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Mask storage needs no reset: entries are only read after being written.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign count = cnt;

endmodule

// File: rtl/rect_linear_grad.sv
// rtl/rect_linear_grad.sv - ReLU backward gate: records forward sign masks, zeroes gradients of negative activations
module rect_linear_grad
  import rect_linear_grad_pkg::*;
#(
  parameter int MASK_DEPTH = RELU_MASK_DEPTH,
  localparam int CW        = $clog2(MASK_DEPTH) + 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 fwd_valid,
  input  logic [NN_BITWIDTH:0] fwd_in,
  output logic                 fwd_ready,
  input  logic                 grad_valid,
  input  logic [NN_BITWIDTH:0] grad_in,
  output logic                 grad_ready,
  output logic                 grad_out_valid,
  output logic [NN_BITWIDTH:0] grad_out,
  input  logic                 grad_out_ready,
  output logic [CW-1:0]        mask_count
);

  logic fifo_full;
  logic fifo_empty;
  logic mask_bit;
  logic push;
  logic pop;
  logic unused_fwd_bits;

  // Only the sign of the pre-activation matters for the mask.
  assign unused_fwd_bits = ^fwd_in[NN_BITWIDTH-1:0];

  // Ready terms depend only on registered state and grad_out_ready.
  assign fwd_ready  = !fifo_full;
  assign grad_ready = !fifo_empty && (!grad_out_valid || grad_out_ready);

  assign push = fwd_valid && fwd_ready;
  assign pop  = grad_valid && grad_ready;

  rect_linear_grad_mask_fifo #(
    .DEPTH (MASK_DEPTH)
  ) u_mask_fifo (
    .clock (clock),
    .reset (reset),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .din   (~fwd_in[NN_BITWIDTH]),
    .dout  (mask_bit),
    .count (mask_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Output register: load gated gradient on pop, drop valid once consumed.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      grad_out_valid <= 1'b0;
      grad_out       <= '0;
    end else if (flush) begin
      grad_out_valid <= 1'b0;
      grad_out       <= '0;
    end else if (pop) begin
      grad_out_valid <= 1'b1;
      grad_out       <= mask_bit ? grad_in : '0;
    end else if (grad_out_ready) begin
      grad_out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rect_linear_grad.sv
// tb/tb_rect_linear_grad.sv - scoreboard bench for rect_linear_grad with a queue-based reference model
module tb_rect_linear_grad;
  import rect_linear_grad_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic                 clock = 1'b0;
  logic                 reset = 1'b0;
  logic                 flush = 1'b0;
  logic                 fwd_valid = 1'b0;
  logic [NN_BITWIDTH:0] fwd_in = '0;
  logic                 fwd_ready;
  logic                 grad_valid = 1'b0;
  logic [NN_BITWIDTH:0] grad_in = '0;
  logic                 grad_ready;
  logic                 grad_out_valid;
  logic [NN_BITWIDTH:0] grad_out;
  logic                 grad_out_ready = 1'b0;
  logic [CW-1:0]        mask_count;

  rect_linear_grad #(.MASK_DEPTH(DEPTH)) dut (
    .clock          (clock),
    .reset          (reset),
    .flush          (flush),
    .fwd_valid      (fwd_valid),
    .fwd_in         (fwd_in),
    .fwd_ready      (fwd_ready),
    .grad_valid     (grad_valid),
    .grad_in        (grad_in),
    .grad_ready     (grad_ready),
    .grad_out_valid (grad_out_valid),
    .grad_out       (grad_out),
    .grad_out_ready (grad_out_ready),
    .mask_count     (mask_count)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Reference model: stored masks, expected outputs in order, pending-output flag.
  bit                   mq[$];
  logic [NN_BITWIDTH:0] exp_q[$];
  logic [NN_BITWIDTH:0] obs_q[$];
  bit                   pend = 1'b0;

  task automatic chk(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: just before each rising edge, a presented and accepted output is scored.
  initial begin
    forever begin
      @(negedge clock);
      #3;
      if (grad_out_valid === 1'b1 && grad_out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL grad_out_unexpected actual=%0h required=no_output at %0t", grad_out, $time);
        end else begin
          chk("grad_out", grad_out, exp_q.pop_front());
          obs_q.push_back(grad_out);
        end
      end
    end
  end

  // One clock cycle of stimulus; checks ready/count/valid against the model and advances it.
  task automatic step(input logic fv, input logic [NN_BITWIDTH:0] fin, input logic gv,
                      input logic [NN_BITWIDTH:0] gin, input logic gor, input logic fl);
    bit exp_fr, exp_gr, m;
    @(negedge clock);
    #1;
    fwd_valid      = fv;
    fwd_in         = fin;
    grad_valid     = gv;
    grad_in        = gin;
    grad_out_ready = gor;
    flush          = fl;
    #1;
    exp_fr = (mq.size() != DEPTH);
    exp_gr = (mq.size() != 0) && (!pend || gor);
    chk("fwd_ready", fwd_ready, exp_fr);
    chk("grad_ready", grad_ready, exp_gr);
    chk("mask_count", mask_count, mq.size());
    chk("grad_out_valid", grad_out_valid, pend);
    if (fl) begin
      mq.delete();
      exp_q.delete();
      pend = 1'b0;
    end else begin
      if (gv && exp_gr) begin
        m = mq.pop_front();
        exp_q.push_back(m ? gin : '0);
      end
      pend = (gv && exp_gr) || (pend && !gor);
      if (fv && exp_fr) mq.push_back(!fin[NN_BITWIDTH]);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    #1;
    fwd_valid      = 1'b0;
    grad_valid     = 1'b0;
    grad_out_ready = 1'b0;
    flush          = 1'b0;
    #1;
    reset = 1'b0;
    #1;
    chk("rst_grad_out_valid", grad_out_valid, 0);
    chk("rst_grad_out", grad_out, 0);
    chk("rst_mask_count", mask_count, 0);
    chk("rst_fwd_ready", fwd_ready, 1);
    chk("rst_grad_ready", grad_ready, 0);
    mq.delete();
    exp_q.delete();
    pend = 1'b0;
    @(negedge clock);
    #1;
    reset = 1'b1;
  endtask

  logic [NN_BITWIDTH:0] basic_fwd  [4];
  logic [NN_BITWIDTH:0] basic_grad [4];
  logic [NN_BITWIDTH:0] basic_exp  [4];

  initial begin
    basic_fwd  = '{16'h0005, 16'hFFFB, 16'h0000, 16'h8000};
    basic_grad = '{16'h0010, 16'h0020, 16'h0030, 16'h0040};
    basic_exp  = '{16'h0010, 16'h0000, 16'h0030, 16'h0000};

    // Reset state, before any clock edge.
    #2;
    chk("init_grad_out_valid", grad_out_valid, 0);
    chk("init_grad_out", grad_out, 0);
    chk("init_mask_count", mask_count, 0);
    chk("init_fwd_ready", fwd_ready, 1);
    chk("init_grad_ready", grad_ready, 0);
    @(negedge clock);
    #1;
    reset = 1'b1;

    // Basic gating.
    obs_q.delete();
    for (int i = 0; i < 4; i++) step(1, basic_fwd[i], 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, basic_grad[i], 1, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    chk("basic_out_count", obs_q.size(), 4);
    for (int i = 0; i < 4 && i < obs_q.size(); i++) chk("basic_out_value", obs_q[i], basic_exp[i]);
    chk("basic_mask_count_end", mask_count, 0);

    // Empty: gradient offered with nothing stored, then a push makes it poppable next cycle.
    step(0, 0, 1, 16'h1234, 1, 0);
    step(0, 0, 1, 16'h1234, 1, 0);
    step(1, 16'h0001, 1, 16'h1234, 1, 0);
    step(0, 0, 1, 16'h4321, 1, 0);
    step(0, 0, 0, 0, 1, 0);

    // Full: hold fwd_valid, then one pop frees a slot.
    for (int i = 0; i < 4; i++) step(1, 16'(i * 16'h7001), 0, 0, 1, 0);
    step(1, 16'h0002, 0, 0, 1, 0);
    step(1, 16'h0002, 0, 0, 1, 0);
    chk("full_mask_count", mask_count, 4);
    chk("full_fwd_ready", fwd_ready, 0);
    step(1, 16'h0002, 1, 16'h0055, 1, 0);
    step(1, 16'h0002, 0, 0, 1, 0);

    // Backpressure: one pop then 3 stalled cycles, then stream.
    step(0, 0, 1, 16'h0AAA, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 16'h0BBB, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 16'(16'h0C00 + i), 1, 0);
    step(0, 0, 0, 0, 1, 0);

    // Simultaneous push/pop at count 2 through pointer wrap.
    step(1, 16'h0001, 0, 0, 1, 0);
    step(1, 16'hF001, 0, 0, 1, 0);
    for (int i = 0; i < 10; i++) step(1, 16'($urandom), 1, 16'($urandom), 1, 0);
    chk("pp_mask_count", mask_count, 2);

    // Flush at count 3 with an output pending.
    step(1, 16'h0003, 1, 16'h0777, 1, 0);
    step(1, 16'h0004, 0, 0, 0, 0);
    step(0, 0, 1, 16'h0888, 0, 1);
    step(0, 0, 0, 0, 1, 0);
    chk("flush_mask_count", mask_count, 0);
    chk("flush_grad_out_valid", grad_out_valid, 0);

    // Randomized traffic with phases biased toward filling and draining.
    for (int i = 0; i < 800; i++) begin
      bit fl;
      bit fv;
      bit gv;
      int phase;
      phase = (i / 100) % 3;
      fl = ($urandom_range(0, 59) == 0);
      fv = (phase == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      gv = (phase == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 2) != 0);
      if (i == 400) do_reset();
      step(fv, 16'($urandom), gv, 16'($urandom), fl ? 1'b0 : ($urandom_range(0, 3) != 0), fl);
    end

    // Drain outputs and require the scoreboard to be empty.
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 0);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
